// File: rtl/bit_serial_adder_if.sv
// Handshake and operand/result bundle for bit_serial_adder.
// The overflow signal exists only when BSA_SIGNED_OVF_EN is defined.
interface bit_serial_adder_if #(
  parameter int unsigned WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] input_a;
  logic [WIDTH-1:0] input_b;
  logic             carry_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
`ifdef BSA_SIGNED_OVF_EN
  logic             overflow;
`endif

  // Controlling logic: issues requests, observes results.
  modport master (
    output start,
    output input_a,
    output input_b,
    output carry_in,
    input  busy,
    input  done,
    input  sum,
`ifdef BSA_SIGNED_OVF_EN
    input  overflow,
`endif
    input  carry_out
  );

  // Adder side: consumes requests, produces results.
  modport slave (
    input  start,
    input  input_a,
    input  input_b,
    input  carry_in,
    output busy,
    output done,
    output sum,
`ifdef BSA_SIGNED_OVF_EN
    output overflow,
`endif
    output carry_out
  );

endinterface

// File: rtl/bit_serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder cell reused over WIDTH cycles,
// LSB first, with a carry flip-flop between cycles.
// Optional feature macro: BSA_SIGNED_OVF_EN adds a registered signed-overflow
// flag (bus.overflow); without it the flag and its logic are absent.

// Single-bit combinational full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic carry_in,
  output logic sum,
  output logic carry_out
);

  // Sum and carry of three one-bit inputs.
  always_comb begin
    sum       = a ^ b ^ carry_in;
    carry_out = (a & b) | (carry_in & (a ^ b));
  end

endmodule

module bit_serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  bit_serial_adder_if.slave   bus
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_n;

  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sw;
  logic [WIDTH-1:0] sw_n;
  logic             c;
  logic [CNT_W-1:0] cnt;

  logic             fa_sum;
  logic             fa_cout;

  logic             load_c;
  logic             step_c;
  logic             last_c;

  // The one shared adder cell, fed from the LSBs of the operand shifters.
  full_adder u_fa (
    .a         (sa[0]),
    .b         (sb[0]),
    .carry_in  (c),
    .sum       (fa_sum),
    .carry_out (fa_cout)
  );

  // Working register after this step: new sum bit enters at the MSB.
  always_comb begin
    sw_n = {fa_sum, sw[WIDTH-1:1]};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and datapath control strobes.
  always_comb begin
    state_n = state;
    load_c  = 1'b0;
    step_c  = 1'b0;
    last_c  = (cnt == CNT_W'(WIDTH - 1));
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          load_c  = 1'b1;
          state_n = ST_ADD;
        end
      end
      ST_ADD: begin
        step_c = 1'b1;
        if (last_c) begin
          state_n = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.start) begin
          load_c  = 1'b1;
          state_n = ST_ADD;
        end else begin
          state_n = ST_IDLE;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Operand shifters, carry FF, bit counter and working register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa  <= '0;
      sb  <= '0;
      sw  <= '0;
      c   <= 1'b0;
      cnt <= '0;
    end else if (load_c) begin
      sa  <= bus.input_a;
      sb  <= bus.input_b;
      sw  <= '0;
      c   <= bus.carry_in;
      cnt <= '0;
    end else if (step_c) begin
      sa <= {1'b0, sa[WIDTH-1:1]};
      sb <= {1'b0, sb[WIDTH-1:1]};
      sw <= sw_n;
      c  <= fa_cout;
      // Hold at WIDTH-1 on the final step so the counter never wraps.
      if (!last_c) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Result registers: updated only on the edge that enters DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.sum       <= '0;
      bus.carry_out <= 1'b0;
`ifdef BSA_SIGNED_OVF_EN
      bus.overflow  <= 1'b0;
`endif
    end else if (step_c && last_c) begin
      bus.sum       <= sw_n;
      bus.carry_out <= fa_cout;
`ifdef BSA_SIGNED_OVF_EN
      // Carry into the MSB is c; carry out of the MSB is fa_cout.
      bus.overflow  <= c ^ fa_cout;
`endif
    end
  end

  // Registered status flags, aligned with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.busy <= (state_n == ST_ADD);
      bus.done <= (state_n == ST_DONE);
    end
  end

endmodule

// File: tb/tb_bit_serial_adder.sv
// Scoreboard bench for bit_serial_adder (WIDTH=8). Expected results are
// queued when a start is issued and retired on each done pulse.
module tb_bit_serial_adder;

  localparam int unsigned W = 8;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    int           ref_edge;
    int           lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_cnt = 0;
  int   busy_cycles = 0;
  logic [W-1:0] held_sum = '0;
  logic         held_co = 1'b0;

  always #5 clk = ~clk;

  bit_serial_adder_if #(.WIDTH(W)) bus ();

  bit_serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                                 input int ref_edge, input int lat);
    exp_t e;
    logic [W:0] full;
    full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    e.s  = full[W-1:0];
    e.co = full[W];
    e.ov = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    e.ref_edge = ref_edge;
    e.lat = lat;
    return e;
  endfunction

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Output monitor: hold checks during ADD, scoreboard retire on done.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst_n) begin
      sb_q.delete();
      busy_cycles = 0;
      held_sum = '0;
      held_co = 1'b0;
    end else begin
      if (bus.busy) begin
        busy_cycles++;
        check_eq("hold_sum", 32'(bus.sum), 32'(held_sum));
        check_eq("hold_co", 32'(bus.carry_out), 32'(held_co));
      end
      if (bus.done) begin
        check_eq("busy_in_done", 32'(bus.busy), 32'd0);
        if (sb_q.size() == 0) begin
          check_eq("spurious_done", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check_eq("sum", 32'(bus.sum), 32'(e.s));
          check_eq("carry_out", 32'(bus.carry_out), 32'(e.co));
`ifdef BSA_SIGNED_OVF_EN
          check_eq("overflow", 32'(bus.overflow), 32'(e.ov));
`endif
          check_eq("latency", 32'(edge_cnt - e.ref_edge), 32'(e.lat));
          check_eq("busy_cycles", 32'(busy_cycles), 32'(W));
          held_sum = e.s;
          held_co = e.co;
        end
        busy_cycles = 0;
      end
    end
  end

  // Issue one request; called #1 after a rising edge with the adder not busy.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    bus.start    = 1'b1;
    bus.input_a  = a;
    bus.input_b  = b;
    bus.carry_in = cin;
    sb_q.push_back(model(a, b, cin, edge_cnt, W + 1));
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Wait (bounded) until every queued result has been retired.
  task automatic wait_idle();
    int g;
    g = 0;
    while (sb_q.size() != 0 && g < 60) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (sb_q.size() != 0) begin
      check_eq("timeout", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    int s1;
    int g;
    bus.start    = 1'b0;
    bus.input_a  = '0;
    bus.input_b  = '0;
    bus.carry_in = 1'b0;
    rst_n        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_done", 32'(bus.done), 32'd0);
    check_eq("rst_sum", 32'(bus.sum), 32'd0);
    check_eq("rst_co", 32'(bus.carry_out), 32'd0);
`ifdef BSA_SIGNED_OVF_EN
    check_eq("rst_ovf", 32'(bus.overflow), 32'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // T1 / T2: basic sums, carry out, carry in.
    run_op(8'h0F, 8'h01, 1'b0);
    wait_idle();
    run_op(8'hFF, 8'h01, 1'b0);
    wait_idle();
    run_op(8'h00, 8'h00, 1'b1);
    wait_idle();

    // T3: start pulse while busy must be ignored.
    run_op(8'h12, 8'h34, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    bus.start   = 1'b1;
    bus.input_a = 8'hFF;
    bus.input_b = 8'hFF;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_idle();
    repeat (4) @(posedge clk);
    #1;

    // T4: asynchronous reset in the middle of ADD.
    run_op(8'hAA, 8'h55, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("arst_busy", 32'(bus.busy), 32'd0);
    check_eq("arst_done", 32'(bus.done), 32'd0);
    check_eq("arst_sum", 32'(bus.sum), 32'd0);
    check_eq("arst_co", 32'(bus.carry_out), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    run_op(8'hAA, 8'h55, 1'b1);
    wait_idle();

    // T5: back-to-back with start held high across DONE.
    s1 = edge_cnt;
    bus.start    = 1'b1;
    bus.input_a  = 8'h3C;
    bus.input_b  = 8'hC4;
    bus.carry_in = 1'b0;
    sb_q.push_back(model(8'h3C, 8'hC4, 1'b0, s1, W + 1));
    @(posedge clk);
    #1;
    bus.input_a  = 8'h81;
    bus.input_b  = 8'h7E;
    bus.carry_in = 1'b1;
    sb_q.push_back(model(8'h81, 8'h7E, 1'b1, s1, 2 * (W + 1)));
    g = 0;
    while (sb_q.size() > 1 && g < 40) begin
      @(posedge clk);
      #1;
      g++;
    end
    check_eq("b2b_first_retired", 32'(sb_q.size() <= 1), 32'd1);
    bus.start = 1'b0;
    wait_idle();

    // Random sweep against A+B+cin.
    for (int i = 0; i < 40; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom));
      wait_idle();
    end

`ifdef BSA_SIGNED_OVF_EN
    // T6: signed overflow flag.
    run_op(8'h7F, 8'h01, 1'b0);
    wait_idle();
    run_op(8'h80, 8'hFF, 1'b0);
    wait_idle();
    run_op(8'h10, 8'h20, 1'b0);
    wait_idle();
`endif

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
